// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the boot loader.
// master is the loader side; slave is the byte source / memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: [count][4*N big-endian data bytes][xor checksum],
// writes words from address 0 and releases cpu_hold only after a good checksum.
module imem_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr  = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StCsum = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] last_idx_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        csum_q;
  logic [DATA_W-9:0] asm_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_q;
  logic              hold_q;
  logic              hs;
  logic              start_ok;
  logic              word_end;

  assign busy     = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
  assign done     = (state_q == StDone);
  assign err      = err_q;
  assign cpu_hold = hold_q;

  assign bus.rx_ready = busy;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  assign hs       = bus.rx_valid && bus.rx_ready;
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign word_end = hs && (byte_cnt_q == 2'd3);

  // wr_addr doubles as the word index: the previous word's increment always lands
  // at least two cycles before the next word's fourth byte arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StHdr;
      StHdr:          if (hs) state_d = StData;
      StData:         if (word_end && (wr_addr_q == last_idx_q)) state_d = StCsum;
      StCsum:         if (hs) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      last_idx_q <= '0;
      wr_addr_q  <= '0;
      csum_q     <= 8'd0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if (wr_en_q) wr_addr_q <= wr_addr_q + AddrOne;

      if (hs) begin
        csum_q <= csum_q ^ bus.rx_data;
        case (state_q)
          // count 0 wraps to an all-ones last index, i.e. 64 words
          StHdr: last_idx_q <= bus.rx_data[ADDR_W-1:0] - AddrOne;
          StData: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {asm_q[DATA_W-17:0], bus.rx_data};
            if (byte_cnt_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= {asm_q, bus.rx_data};
            end
          end
          StCsum: begin
            err_q  <= (bus.rx_data != csum_q);
            hold_q <= (bus.rx_data != csum_q);
          end
          default: ;
        endcase
      end

      if (start_ok) begin
        err_q      <= 1'b0;
        hold_q     <= 1'b1;
        csum_q     <= 8'd0;
        byte_cnt_q <= 2'd0;
        asm_q      <= '0;
        wr_addr_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, randomized frames against a
// frame-level reference model, and hand-written reset/start/gap sequences.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy, done, err, cpu_hold;

  imem_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  imem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int unsigned c;
  } wr_t;

  typedef struct {
    logic [7:0] count;
    bit         bad;
    bit         gap;
    logic       exp_err;
    logic       exp_hold;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  wr_t         wr_q[$];
  wr_t         ref_q[$];
  int unsigned hs_cyc[$];
  logic [7:0]  tx_q[$];
  wr_t         mon_w;
  vec_t        vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Writes and handshakes are observed mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      mon_w.addr = bus.wr_addr;
      mon_w.data = bus.wr_data;
      mon_w.c    = cyc;
      wr_q.push_back(mon_w);
    end
    if (bus.rx_valid && bus.rx_ready) hs_cyc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    hs_cyc.delete();
  endtask

  task automatic send_bytes(input int first, input int last, input bit gap);
    bit taken;
    int guard;
    for (int i = first; i <= last; i++) begin
      taken = 1'b0;
      guard = 0;
      while (!taken) begin
        bus.rx_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rx_data  = bus.rx_valid ? tx_q[i] : 8'($urandom);
        @(negedge clk);
        taken = bus.rx_valid && bus.rx_ready;
        tick();
        guard++;
        if (guard > 64 && !taken) begin
          chk("byte_accept", 64'(taken), 64'd1);
          bus.rx_valid = 1'b0;
          return;
        end
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  // Frame of `count` words of random data; a bad frame gets a nonzero checksum error.
  task automatic build_frame(input logic [7:0] count, input bit bad);
    int n;
    logic [7:0] x;
    logic [7:0] b;
    n = (count == 8'd0) ? 64 : int'(count);
    tx_q.delete();
    tx_q.push_back(count);
    x = count;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
      x ^= b;
    end
    tx_q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic load(input bit do_start, input bit gap);
    clear_mon();
    if (do_start) pulse_start();
    send_bytes(0, tx_q.size() - 1, gap);
    @(negedge clk);
  endtask

  // Reference: N words at addresses 0..N-1, big-endian, err iff xor of frame body != last byte.
  task automatic check_load(input string tag);
    int n;
    logic [7:0] x;
    logic bad;
    logic [31:0] w;
    n = (tx_q[0] == 8'd0) ? 64 : int'(tx_q[0]);
    x = 8'd0;
    for (int i = 0; i < tx_q.size() - 1; i++) x ^= tx_q[i];
    bad = (x != tx_q[tx_q.size() - 1]);
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      w = {tx_q[1 + 4*i], tx_q[2 + 4*i], tx_q[3 + 4*i], tx_q[4 + 4*i]};
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_q[i].addr), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wr_q[i].data), 64'(w));
    end
    chk({tag, "_nhs"}, 64'(hs_cyc.size()), 64'(tx_q.size()));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'(bad));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(bad));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{count: 8'd1, bad: 1'b0, gap: 1'b0, exp_err: 1'b0, exp_hold: 1'b0};
    vecs[1] = '{count: 8'd3, bad: 1'b1, gap: 1'b0, exp_err: 1'b1, exp_hold: 1'b1};
    vecs[2] = '{count: 8'd5, bad: 1'b0, gap: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
    vecs[3] = '{count: 8'd2, bad: 1'b1, gap: 1'b1, exp_err: 1'b1, exp_hold: 1'b1};
    vecs[4] = '{count: 8'd8, bad: 1'b0, gap: 1'b0, exp_err: 1'b0, exp_hold: 1'b0};
    vecs[5] = '{count: 8'd4, bad: 1'b0, gap: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Bytes offered in IDLE are not consumed
    clear_mon();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    repeat (4) tick();
    bus.rx_valid = 1'b0;
    chk("idle_no_hs", 64'(hs_cyc.size()), 64'd0);
    chk("idle_hold", 64'(cpu_hold), 64'd1);

    // Single word with exact strobe timing
    tx_q = '{8'h01, 8'h01, 8'h09, 8'h38, 8'h22, 8'h13};
    load(1'b1, 1'b0);
    check_load("single");
    if (wr_q.size() == 1 && hs_cyc.size() == 6)
      chk("single_strobe_cycle", 64'(wr_q[0].c), 64'(hs_cyc[4] + 1));
    else
      chk("single_strobe_seen", 64'(wr_q.size()), 64'd1);
    chk("single_wr_data", 64'(wr_q.size() > 0 ? wr_q[0].data : 32'h0), 64'h01093822);

    // Start in DONE after a good load: hold reasserts, address restarts
    pulse_start();
    chk("restart_hold", 64'(cpu_hold), 64'd1);
    chk("restart_err", 64'(err), 64'd0);
    chk("restart_addr", 64'(bus.wr_addr), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);

    // Bad checksum, continuing the frame already started
    tx_q = '{8'h01, 8'h01, 8'h09, 8'h38, 8'h22, 8'h12};
    load(1'b0, 1'b0);
    check_load("badcsum");

    // Start in DONE after a bad load clears err
    pulse_start();
    chk("restart_bad_err", 64'(err), 64'd0);
    chk("restart_bad_hold", 64'(cpu_hold), 64'd1);

    // Full depth: count 0 means 64 words, word k = {k,k,k,k}, checksum 0
    tx_q.delete();
    tx_q.push_back(8'h00);
    for (int k = 0; k < 64; k++) repeat (4) tx_q.push_back(8'(k));
    tx_q.push_back(8'h00);
    load(1'b0, 1'b0);
    check_load("full");
    if (wr_q.size() == 64) begin
      chk("full_last_addr", 64'(wr_q[63].addr), 64'h3F);
      chk("full_last_data", 64'(wr_q[63].data), 64'h3F3F3F3F);
    end else begin
      chk("full_count", 64'(wr_q.size()), 64'd64);
    end

    // Gapped stream matches the ungapped run
    build_frame(8'd2, 1'b0);
    load(1'b1, 1'b0);
    ref_q = wr_q;
    load(1'b1, 1'b1);
    check_load("gapped");
    chk("gapped_nhs10", 64'(hs_cyc.size()), 64'd10);
    chk("gapped_nwr_ref", 64'(wr_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("gapped_ref_addr%0d", i), 64'(wr_q[i].addr), 64'(ref_q[i].addr));
      chk($sformatf("gapped_ref_data%0d", i), 64'(wr_q[i].data), 64'(ref_q[i].data));
    end

    // Start pulsed mid-DATA is ignored
    build_frame(8'd3, 1'b0);
    clear_mon();
    pulse_start();
    send_bytes(0, 2, 1'b0);
    pulse_start();
    chk("start_in_data_busy", 64'(busy), 64'd1);
    send_bytes(3, tx_q.size() - 1, 1'b0);
    @(negedge clk);
    check_load("start_in_data");

    // Reset mid-load: no write, back to IDLE with hold, then a clean reload
    build_frame(8'd2, 1'b0);
    clear_mon();
    pulse_start();
    send_bytes(0, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(bus.rx_ready), 64'd0);
    chk("midrst_hold", 64'(cpu_hold), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    tick();
    tick();
    chk("midrst_no_write", 64'(wr_q.size()), 64'd0);
    rst_n = 1'b1;
    tick();
    build_frame(8'd2, 1'b0);
    load(1'b1, 1'b0);
    check_load("after_rst");

    // Table-driven frames
    foreach (vecs[v]) begin
      build_frame(vecs[v].count, vecs[v].bad);
      load(1'b1, vecs[v].gap);
      check_load($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_tbl_err", v), 64'(err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_tbl_hold", v), 64'(cpu_hold), 64'(vecs[v].exp_hold));
    end

    // Randomized frames against the reference model
    for (int r = 0; r < 8; r++) begin
      build_frame(8'($urandom_range(1, 16)), 1'($urandom_range(0, 1)));
      load(1'b1, 1'($urandom_range(0, 1)));
      check_load($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 64-word instruction memory: receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to sequential instruction-memory addresses starting at 0.
- Checks an XOR checksum over the whole frame.
- Holds the CPU in reset (cpu_hold) from power-up until a load completes with a good checksum.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (depth = 2^ADDR_W = 64).
- DATA_W, 32, instruction width; must equal 4 bytes.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte this cycle; handshake = rx_valid & rx_ready
- wr_en  output  1  instruction-memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  DATA_W  word to write
- busy  output  1  high in HDR, DATA, CSUM
- done  output  1  level, high in DONE
- err  output  1  sticky checksum-mismatch flag
- cpu_hold  output  1  high keeps the CPU in reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, cpu_hold=1.
  - Internal byte counter, word counter, checksum accumulator and assembly register all cleared.
  - Reset mid-load abandons the frame with no further writes; words already written stay in memory.
- Frame format:
  - [count byte][4*N data bytes][checksum byte].
  - N = count, except count=0 means N=64.
  - Data bytes are big-endian: the first byte of each group goes to bits 31:24.
  - The checksum byte must equal the XOR of the count byte and all data bytes.
- States:
  - IDLE: rx_ready=0.
    - start -> HDR.
    - On entry to HDR: clear err, checksum accumulator, word and byte counters, and wr_addr; set cpu_hold=1.
  - HDR: rx_ready=1.
    - On handshake: latch N, accumulator ^= byte, -> DATA.
  - DATA: rx_ready=1.
    - On each handshake: shift the byte into the assembly register, accumulator ^= byte, byte counter increments mod 4.
    - On the 4th byte of a word, in the next cycle: wr_en=1 for exactly one cycle, wr_data = assembled word, wr_addr = current word index.
    - wr_addr increments in the cycle after the strobe; it wraps 63->0 only after the 64th word, and that wrap is unobservable because the frame ends.
    - After the 4th byte of word N-1: -> CSUM.
  - CSUM: rx_ready=1.
    - On handshake: compare byte with accumulator.
    - Match: err=0, cpu_hold=0.
    - Mismatch: err=1, cpu_hold stays 1.
    - Either way -> DONE.
  - DONE: rx_ready=0, done=1.
    - start -> HDR (cpu_hold reasserts to 1 the cycle after start).
- Handshake and timing:
  - start while busy is ignored.
  - rx_valid may drop at any time. Bytes are consumed only on handshake; no bytes are lost or duplicated across gaps.
  - Back-to-back bytes (rx_valid held high) sustain 1 byte/cycle. No backpressure is needed for writes, because a write occupies one cycle and the next word completes ≥4 cycles later.
  - The final write strobe of a frame may coincide with the CSUM cycle; both complete normally.
  - Bytes presented with rx_valid=1 in IDLE or DONE are not consumed (rx_ready=0).

Test Plan:
- Single word:
  - Stimulus: reset, start, bytes 01,01,09,38,22,13.
  - Required: one wr_en pulse with wr_addr=0x00, wr_data=0x01093822, the cycle after byte 0x22 is accepted; DONE with err=0, cpu_hold=0.
- Bad checksum:
  - Stimulus: same frame with checksum 0x12.
  - Required: the write still occurs; done=1, err=1, cpu_hold=1.
- Full depth:
  - Stimulus: count=00, 256 data bytes where word k = {k,k,k,k}, correct checksum.
  - Required: 64 writes with addresses 0x00..0x3F in order and wr_data=0x3F3F3F3F at address 0x3F; err=0.
- Gapped stream:
  - Stimulus: 2-word frame with rx_valid toggling randomly, including gaps mid-word.
  - Required: identical writes and addresses to the ungapped run; exactly 10 handshakes total.
- Reset mid-load:
  - Stimulus: rst_n low after 3 data bytes of a 2-word frame.
  - Required: immediately IDLE, cpu_hold=1, no wr_en pulse.
  - Follow-up: a subsequent start plus a good frame loads correctly from address 0.
- Start handling:
  - Stimulus: start pulsed in DATA.
  - Required: ignored.
  - Stimulus: start in DONE after a good load.
  - Required: cpu_hold=1 next cycle, err cleared, wr_addr restarts at 0.
